// File: rtl/present_inv_key_schedule_if.sv
// Handshake bundle between the decrypt datapath and the PRESENT-80 reverse
// round-key source: key load/start, step request and round-key outputs.
interface present_inv_key_schedule_if;
    logic        start;
    logic [79:0] key;
    logic        rk_next;
    logic        end_key_generation;
    logic        rk_valid;
    logic [63:0] round_key;
    logic [5:0]  round_idx;

    modport master (
        output start,
        output key,
        output rk_next,
        input  end_key_generation,
        input  rk_valid,
        input  round_key,
        input  round_idx
    );

    modport slave (
        input  start,
        input  key,
        input  rk_next,
        output end_key_generation,
        output rk_valid,
        output round_key,
        output round_idx
    );
endinterface

// File: rtl/present_inv_key_schedule.sv
// PRESENT-80 decryption round-key source. After start the forward schedule is
// run up to the last round key; round keys are then emitted newest-first, each
// rk_next undoing one forward update so no key storage beyond kreg is needed.
module present_inv_key_schedule #(
    parameter int ROUNDS = 31
) (
    input  logic                        clk,
    input  logic                        rst,
    present_inv_key_schedule_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Index of the last forward key; also the counter value that marks the
    // schedule as complete, one cycle after the final forward update.
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS + 1);

    state_t      r_state, w_state_nxt;
    logic [79:0] r_kreg,  w_kreg_nxt;
    logic [5:0]  r_ctr,   w_ctr_nxt;
    logic [5:0]  r_idx,   w_idx_nxt;
    logic        r_end,   w_end_nxt;
    logic        r_valid, w_valid_nxt;
    logic [5:0]  w_inv_i;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'hC: y = 4'h0;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'hB: y = 4'h3;
            4'h9: y = 4'h4;  4'h0: y = 4'h5;  4'hA: y = 4'h6;  4'hD: y = 4'h7;
            4'h3: y = 4'h8;  4'hE: y = 4'h9;  4'hF: y = 4'hA;  4'h8: y = 4'hB;
            4'h4: y = 4'hC;  4'h7: y = 4'hD;  4'h1: y = 4'hE;  4'h2: y = 4'hF;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Forward step: rotate left by 61, S-box the top nibble, mix in the round counter.
    function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ i;
        return t;
    endfunction

    // Inverse step: the forward operations undone in reverse order.
    function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ i;
        t[79:76]   = sbox_inv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    assign w_inv_i = r_idx - 6'd1;

    // Next-state and next-register computation; start overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_kreg_nxt  = r_kreg;
        w_ctr_nxt   = r_ctr;
        w_idx_nxt   = r_idx;
        w_end_nxt   = r_end;
        w_valid_nxt = r_valid;
        if (bus.start) begin
            w_state_nxt = ST_FWD;
            w_kreg_nxt  = bus.key;
            w_ctr_nxt   = 6'd1;
            w_idx_nxt   = 6'd0;
            w_end_nxt   = 1'b0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_FWD: begin
                    if (r_ctr == LAST_IDX) begin
                        w_state_nxt = ST_READY;
                        w_idx_nxt   = LAST_IDX;
                        w_end_nxt   = 1'b1;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_kreg_nxt  = fwd_update(r_kreg, r_ctr[4:0]);
                        w_ctr_nxt   = r_ctr + 6'd1;
                    end
                end
                ST_READY: begin
                    if (bus.rk_next) begin
                        if (r_idx > 6'd1) begin
                            w_kreg_nxt = inv_update(r_kreg, w_inv_i[4:0]);
                            w_idx_nxt  = r_idx - 6'd1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = 6'd0;
                            w_end_nxt   = 1'b0;
                            w_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ST_READY;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and key registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_kreg  <= 80'd0;
            r_ctr   <= 6'd0;
            r_idx   <= 6'd0;
            r_end   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kreg  <= w_kreg_nxt;
            r_ctr   <= w_ctr_nxt;
            r_idx   <= w_idx_nxt;
            r_end   <= w_end_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.round_key          = r_kreg[79:16];
    assign bus.round_idx          = r_idx;
    assign bus.end_key_generation = r_end;
    assign bus.rk_valid           = r_valid;

endmodule

// File: tb/tb_present_inv_key_schedule.sv
// Directed and randomised checks of the reverse round-key source against a
// forward-only reference schedule held in the bench.
module tb_present_inv_key_schedule;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [63:0] gk [1:32];
    logic [3:0]  sb [0:15];

    present_inv_key_schedule_if bus();

    present_inv_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] model_fwd(input logic [79:0] k, input int i);
        logic [79:0] t;
        logic [4:0]  c;
        c        = 5'(i);
        t        = (k >> 19) | (k << 61);
        t[79:76] = sb[t[79:76]];
        t[19:15] = t[19:15] ^ c;
        return t;
    endfunction

    task automatic gen_golden(input logic [79:0] k);
        logic [79:0] t;
        t     = k;
        gk[1] = t[79:16];
        for (int i = 1; i <= 31; i++) begin
            t         = model_fwd(t, i);
            gk[i + 1] = t[79:16];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [79:0] k);
        bus.key   = k;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts cycles from the start edge until end_key_generation rises.
    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (!bus.end_key_generation && cnt < 100) begin
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, 80'(cnt), 80'd32);
        chk({tag, "_k32"}, 80'(bus.round_key), 80'(gk[32]));
    endtask

    // Steps through all reverse keys; hold keeps rk_next high throughout.
    task automatic walk(input string tag, input int max_gap, input bit hold);
        int g;
        for (int j = 32; j >= 1; j--) begin
            if (!hold) begin
                g = $urandom_range(max_gap, 0);
                repeat (g) tick();
            end
            chk({tag, "_idx"},   80'(bus.round_idx), 80'(j));
            chk({tag, "_rk"},    80'(bus.round_key), 80'(gk[j]));
            chk({tag, "_valid"}, 80'(bus.rk_valid), 80'd1);
            bus.rk_next = 1'b1;
            tick();
            if (!hold) bus.rk_next = 1'b0;
        end
        bus.rk_next = 1'b0;
        chk({tag, "_done_valid"}, 80'(bus.rk_valid), 80'd0);
        chk({tag, "_done_end"},   80'(bus.end_key_generation), 80'd0);
        chk({tag, "_done_idx"},   80'(bus.round_idx), 80'd0);
    endtask

    // rk_next while idle must not move anything; kreg holds the original key.
    task automatic idle_poke(input string tag, input logic [79:0] k);
        bus.rk_next = 1'b1;
        tick();
        tick();
        bus.rk_next = 1'b0;
        chk({tag, "_idle_idx"},   80'(bus.round_idx), 80'd0);
        chk({tag, "_idle_valid"}, 80'(bus.rk_valid), 80'd0);
        chk({tag, "_idle_key"},   80'(bus.round_key), 80'(k[79:16]));
    endtask

    initial begin
        logic [79:0] k;
        logic [31:0] ra, rb, rc;

        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        bus.start   = 1'b0;
        bus.key     = 80'd0;
        bus.rk_next = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 80'(bus.rk_valid), 80'd0);
        chk("rst_end",   80'(bus.end_key_generation), 80'd0);
        chk("rst_rk",    80'(bus.round_key), 80'd0);
        chk("rst_idx",   80'(bus.round_idx), 80'd0);
        rst = 1'b0;
        tick();

        // Cases 1 and 2: zero key, pulsed rk_next, final key is zero.
        gen_golden(80'd0);
        start_key(80'd0);
        wait_ready("zero");
        chk("zero_end_idx", 80'(bus.round_idx), 80'd32);
        walk("zero", 0, 1'b0);
        idle_poke("zero", 80'd0);

        // Case 3: all-ones key with rk_next held high.
        k = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        gen_golden(k);
        start_key(k);
        wait_ready("ones");
        walk("ones", 0, 1'b1);
        chk("ones_last_rk", 80'(bus.round_key), 80'h0000_FFFF_FFFF_FFFF_FFFF);
        idle_poke("ones", k);

        // Case 4: restart during the forward schedule.
        start_key(80'h0123_4567_89AB_CDEF_0F1E);
        repeat (9) tick();
        k = 80'hDEAD_BEEF_CAFE_F00D_1234;
        gen_golden(k);
        start_key(k);
        wait_ready("restart");
        walk("restart", 2, 1'b0);

        // Case 5: asynchronous reset mid-READY at round_idx 17.
        k = 80'h1357_9BDF_2468_ACE0_5A5A;
        gen_golden(k);
        start_key(k);
        wait_ready("rstmid");
        for (int s = 0; s < 15; s++) begin
            bus.rk_next = 1'b1;
            tick();
            bus.rk_next = 1'b0;
        end
        chk("rstmid_idx17", 80'(bus.round_idx), 80'd17);
        chk("rstmid_rk17",  80'(bus.round_key), 80'(gk[17]));
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 80'(bus.rk_valid), 80'd0);
        chk("rstmid_end",   80'(bus.end_key_generation), 80'd0);
        chk("rstmid_rk",    80'(bus.round_key), 80'd0);
        chk("rstmid_idx",   80'(bus.round_idx), 80'd0);
        tick();
        rst = 1'b0;
        tick();
        gen_golden(80'd0);
        start_key(80'd0);
        wait_ready("after_rst");
        walk("after_rst", 1, 1'b0);

        // Case 6: random keys with random rk_next gaps.
        for (int n = 0; n < 100; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            k  = {ra, rb, rc[15:0]};
            gen_golden(k);
            start_key(k);
            wait_ready("rand");
            walk("rand", 3, 1'b0);
            idle_poke("rand", k);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
